// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers and hazard stall request
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             use_md_d,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_stall
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
    } op_t;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q, b_q;
    op_t                op_q;
    logic               is_arith, accept;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               neg_a, neg_b, div_zero, wr_en;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, res_hi, res_lo;

    // Acceptance and the hazard-unit stall request
    always_comb begin
        busy     = cnt != '0;
        is_arith = md_op >= OP_MULT && md_op <= OP_DIVU;
        accept   = md_start && !busy;
        md_stall = use_md_d && (busy || (md_start && is_arith));
    end

    // Result from latched operands; signed divide goes through magnitudes so
    // most-negative / -1 naturally wraps to lo=most-negative, hi=0
    always_comb begin
        prod_s   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        neg_a    = op_q == OP_DIV && a_q[WIDTH-1];
        neg_b    = op_q == OP_DIV && b_q[WIDTH-1];
        mag_a    = neg_a ? -a_q : a_q;
        mag_b    = neg_b ? -b_q : b_q;
        div_zero = b_q == '0;
        quo      = div_zero ? '0 : mag_a / mag_b;
        rem      = div_zero ? '0 : mag_a % mag_b;
        res_lo   = op_q == OP_MULT  ? prod_s[WIDTH-1:0] :
                   op_q == OP_MULTU ? prod_u[WIDTH-1:0] :
                   (neg_a ^ neg_b)  ? -quo : quo;
        res_hi   = op_q == OP_MULT  ? prod_s[2*WIDTH-1:WIDTH] :
                   op_q == OP_MULTU ? prod_u[2*WIDTH-1:WIDTH] :
                   neg_a            ? -rem : rem;
        wr_en    = !((op_q == OP_DIV || op_q == OP_DIVU) && div_zero);
    end

    // Operand latch, busy countdown and HI/LO update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_NONE;
            hi   <= '0;
            lo   <= '0;
        end else if (accept && is_arith) begin
            a_q  <= src_a;
            b_q  <= src_b;
            op_q <= op_t'(md_op);
            cnt  <= (md_op == OP_MULT || md_op == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (accept && md_op == OP_MTHI) begin
            hi <= src_a;
        end else if (accept && md_op == OP_MTLO) begin
            lo <= src_a;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && wr_en) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized scoreboard bench for md_unit against an arithmetic reference model
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 0, reset = 0, md_start = 0, use_md_d = 0;
    logic [2:0]   md_op = 0;
    logic [W-1:0] src_a = 0, src_b = 0;
    logic         busy, md_stall;
    logic [W-1:0] hi, lo;

    int             total = 0, bad = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_hi = 0, m_lo = 0;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .use_md_d(use_md_d),
        .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: update HI/LO from plain 64-bit arithmetic, queue the result, drive one start
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int st);
        longint sa, sb;
        logic [2*W-1:0] p;
        if (op >= 1 && op <= 6) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = {m_hi, m_lo};
            case (op)
                3'd1: p = 64'(sa * sb);
                3'd2: p = {32'd0, a} * {32'd0, b};
                3'd3: if (b != 0) p = {32'(sa % sb), 32'(sa / sb)};
                3'd4: if (b != 0) p = {a % b, a / b};
                3'd5: p[63:32] = a;
                3'd6: p[31:0] = a;
                default: ;
            endcase
            {m_hi, m_lo} = p;
            exp_q.push_back(p);
        end
        md_start = 1;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        if (st >= 0) begin
            #1;
            check("stall_at_start", 64'(md_stall), 64'(st));
        end
        step();
        md_start = 0;
        md_op    = 3'($urandom_range(0, 7));
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
    endtask

    // Monitor: compares HI/LO when a move lands or an arithmetic op finishes
    initial begin
        logic mv = 0, wb = 0;
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset && (mv || (wb && !busy))) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got %h%h expected no result", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_hilo", {hi, lo}, e);
                end
            end
            mv = reset && md_start && !busy && (md_op == 3'd5 || md_op == 3'd6);
            wb = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic late;
        logic [2:0] op;
        logic [W-1:0] a, b;
        #1;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        repeat (2) step();
        reset = 1;
        step();

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, -1);
        check("mult_hold", {hi, lo}, 64'd0);
        wait_idle(n);
        check("mult_len", 64'(n), 64'(MC));
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFE, 32'd3, -1);
        wait_idle(n);
        check("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2, -1);
        wait_idle(n);
        check("div_len", 64'(n), 64'(DC));
        check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        wait_idle(n);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        issue(3'd5, 32'h11, 32'd0, -1);
        issue(3'd6, 32'h22, 32'd0, -1);
        issue(3'd4, 32'd100, 32'd0, -1);
        wait_idle(n);
        check("divz_len", 64'(n), 64'(DC));
        check("divz_hilo", {hi, lo}, 64'h0000_0011_0000_0022);

        issue(3'd3, 32'd1000, 32'd7, -1);
        repeat (2) step();
        md_start = 1;
        md_op    = 3'd1;
        src_a    = $urandom;
        src_b    = $urandom;
        step();
        md_start = 0;
        wait_idle(n);
        check("busy_ignore_len", 64'(n + 3), 64'(DC));
        check("busy_ignore_hilo", {hi, lo}, {32'd6, 32'd142});
        issue(3'd1, 32'd5, 32'd6, -1);
        check("b2b_accept", 64'(busy), 64'(1));
        wait_idle(n);
        check("b2b_hilo", {hi, lo}, {32'd0, 32'd30});

        use_md_d = 1;
        issue(3'd1, 32'd7, 32'd9, 1);
        late = 0;
        n = 0;
        while (busy && n < 50) begin
            if (!md_stall) late = 1;
            step();
            n++;
        end
        check("stall_busy", 64'(late), 64'(0));
        check("stall_drop", 64'(md_stall), 64'(0));
        issue(3'd6, 32'h1234, 32'd0, 0);
        check("mtlo_lo", 64'(lo), 64'h1234);
        check("mtlo_busy", 64'(busy), 64'(0));
        check("mtlo_stall", 64'(md_stall), 64'(0));
        use_md_d = 0;

        repeat (40) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                default: ;
            endcase
            issue(op, a, b, -1);
            wait_idle(n);
            if (op >= 1 && op <= 4) check("rand_len", 64'(n), (op <= 2) ? 64'(MC) : 64'(DC));
            check("rand_state", {hi, lo}, {m_hi, m_lo});
        end

        issue(3'd3, 32'd12345, 32'd17, -1);
        repeat (6) step();
        reset = 0;
        #1;
        check("rst_mid_hi", 64'(hi), 64'(0));
        check("rst_mid_lo", 64'(lo), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        exp_q.delete();
        m_hi = 0;
        m_lo = 0;
        repeat (2) step();
        reset = 1;
        late = 0;
        repeat (15) begin
            step();
            if (hi != 0 || lo != 0 || busy) late = 1;
        end
        check("rst_no_late", 64'(late), 64'(0));

        repeat (3) step();
        check("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the next pipeline generation.
- Sits in E stage beside the ALU and accepts mult/multu/div/divu/mthi/mtlo.
- Emulates a multi-cycle iterative unit with a configurable busy counter.
- Exports a stall request so the hazard logic can hold D-stage instructions that use HI/LO.

Parameters:
- WIDTH, 32, operand and HI/LO width (even, >= 8).
- MULT_CYCLES, 5, busy cycles for mult/multu (>= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_start  in  1  E-stage instruction is an MD operation this cycle.
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- src_a  in  WIDTH  rs value, already forwarded.
- src_b  in  WIDTH  rt value, already forwarded.
- use_md_d  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- md_stall  out  1  stall request to the hazard unit.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, internal counter=0, latched operands/op=0. Reset mid-operation aborts it; no HI/LO update happens after reset releases.

Acceptance:
- A start is accepted at edge t when md_start=1, busy=0 and md_op is 1..6.
- md_start while busy=1, or with md_op 0/7, is ignored: no state change.

Move ops (mthi/mtlo):
- Single cycle.
- hi<=src_a (mthi) or lo<=src_a (mtlo) at the accepting edge.
- busy stays 0.

Arithmetic ops (mult/multu/div/divu):
- At the accepting edge, latch src_a, src_b and op, and load counter with N (MULT_CYCLES or DIV_CYCLES).
- busy = (counter != 0), so busy=1 during cycles t+1..t+N.
- On the edge where counter==1: counter<=0 and hi/lo are written.
- New values are visible in cycle t+N+1, when busy=0.
- hi/lo hold old values throughout busy.
- The result is computed from the latched operands; src_a/src_b changes after acceptance have no effect.

Arithmetic rules:
- mult: signed 2*WIDTH product; hi=upper WIDTH bits, lo=lower.
- multu: same, unsigned.
- div: signed, quotient truncated toward zero; lo=quotient, hi=remainder with the sign of the dividend.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0.
- divu: unsigned; lo=quotient, hi=remainder.
- Divide by zero (src_b==0 for div/divu): the busy period still runs N cycles, and hi/lo remain unchanged at completion.

Stall:
- md_stall = use_md_d & (busy | (md_start & md_op in 1..4)). Combinational.
- mthi/mtlo in E do not request a stall; their result is already valid for a following mfhi/mflo, which reads HI/LO in E one cycle later.

Back-to-back:
- A new start is accepted in the first cycle busy=0, i.e. cycle t+N+1.
- The unit never overlaps operations.

Test Plan:
- Reset with reset=0 mid-divide (counter=4), then release -> hi=0, lo=0, busy=0 immediately and stay 0; no late update.
- mult src_a=0xFFFFFFFE (-2), src_b=3, MULT_CYCLES=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div src_a=-7 (0xFFFFFFF9), src_b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 100 by 0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22.
- Start div, then assert md_start with mult at busy cycle 3 -> mult ignored, final hi/lo match the div only, busy drops at t+11. Next mult at t+11 is accepted.
- use_md_d=1 with md_start=1, md_op=1 -> md_stall=1 in that cycle and through all busy cycles, 0 the cycle busy drops. mtlo src_a=0x1234 -> lo=0x1234 next cycle, busy=0, md_stall=0.
